div_seq_unit: RTL

//   Multi-cycle signed/unsigned 32-bit integer divider for the CPU datapath.

---
 rtl/cpu_div_pkg.sv | 18 +
 rtl/div_sign_adj.sv | 15 +
 rtl/div_seq_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_div_pkg.sv
// Shared definitions for the sequential integer divider.
//   div_state_e  : FSM state encoding (IDLE -> ITER -> FIX -> DONE)
//   DIV_WIDTH    : default datapath width
//   DZ_QUOTIENT  : quotient returned for a zero divisor
package cpu_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sign_adj.sv
// Conditional two's-complement negate (combinational).
//   in     : operand
//   neg_en : 1 = output -in, 0 = pass through
//   out    : result
module div_sign_adj #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg_en,
    output logic [WIDTH-1:0] out
);

    assign out = neg_en ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Signed divides run on magnitudes and fix the signs afterwards
// (truncating: remainder takes the sign of the dividend).
//   clk, rst_n   : clock / async active-low reset
//   start        : request, only honoured in IDLE
//   is_signed    : 1 = two's-complement divide
//   dividend     : numerator, sampled with start
//   divisor      : denominator, sampled with start
//   busy         : ITER/FIX in progress
//   done         : one-cycle result strobe
//   hilo_we      : HI/LO write enable (same as done)
//   quotient     : LO result, held until next accepted start
//   remainder    : HI result, held until next accepted start
//   div_by_zero  : divisor was zero, held like results
module div_seq_unit
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e state, state_nxt;

    logic [WIDTH-1:0] acc_a;     // partial remainder A
    logic [WIDTH-1:0] acc_q;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs_m;     // divisor magnitude M
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;
    logic             dz;
    logic [WIDTH-1:0] raw_dvd;

    logic [WIDTH-1:0] abs_dvd, abs_dvs, q_fix, r_fix;

    div_sign_adj #(.WIDTH(WIDTH)) u_abs_dvd (
        .in(dividend), .neg_en(is_signed & dividend[WIDTH-1]), .out(abs_dvd)
    );
    div_sign_adj #(.WIDTH(WIDTH)) u_abs_dvs (
        .in(divisor), .neg_en(is_signed & divisor[WIDTH-1]), .out(abs_dvs)
    );
    div_sign_adj #(.WIDTH(WIDTH)) u_q_fix (
        .in(acc_q), .neg_en(sign_q), .out(q_fix)
    );
    div_sign_adj #(.WIDTH(WIDTH)) u_r_fix (
        .in(acc_a), .neg_en(sign_r), .out(r_fix)
    );

    // Shifted partial remainder keeps the bit shifted out of A, so the trial
    // subtract stays exact when M >= 2**(WIDTH-1).
    logic [WIDTH:0] part;
    logic [WIDTH:0] trial;
    assign part  = {acc_a, acc_q[WIDTH-1]};
    assign trial = part - {1'b0, dvs_m};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_ITER;
            S_ITER: begin
                busy = 1'b1;
                if (count == CNT_W'(WIDTH-1)) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign hilo_we = done;

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a       <= '0;
            acc_q       <= '0;
            dvs_m       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            raw_dvd     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    acc_a       <= '0;
                    acc_q       <= abs_dvd;
                    dvs_m       <= abs_dvs;
                    count       <= '0;
                    sign_q      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    sign_r      <= is_signed & dividend[WIDTH-1];
                    dz          <= (divisor == '0);
                    raw_dvd     <= dividend;
                    div_by_zero <= 1'b0;
                end
                S_ITER: begin
                    count <= count + CNT_W'(1);
                    if (!trial[WIDTH]) begin
                        acc_a <= trial[WIDTH-1:0];
                        acc_q <= {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        // no borrow-free subtract: part < M, so it fits in WIDTH bits
                        acc_a <= part[WIDTH-1:0];
                        acc_q <= {acc_q[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (dz) begin
                        quotient    <= WIDTH'(DZ_QUOTIENT);
                        remainder   <= raw_dvd;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
